// File: rtl/approx_add_pkg.sv
// Shared types and the reference approximate-sum function for the approx adder.
// Latency: n/a (package). Backpressure: n/a.
// approx_sum works on up to 32-bit operands and is called with a constant k.
package approx_add_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_LOA   = 2'd1,
    MODE_TRUNC = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  localparam int unsigned MAX_W = 32;

  // Mode-selected sum of two zero-extended operands; upper part always exact.
  function automatic logic [MAX_W:0] approx_sum(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input mode_e            mode,
                                                input int unsigned      k);
    logic [MAX_W:0] mask;
    logic [MAX_W:0] lo;
    logic [MAX_W:0] hi;
    logic [MAX_W:0] cin;
    logic [MAX_W:0] res;
    mask = (33'd1 << k) - 33'd1;
    lo   = '0;
    cin  = '0;
    case (mode)
      MODE_LOA: begin
        lo = {1'b0, (a | b)} & mask;
        if (k != 0) cin = 33'((a >> (k - 1)) & (b >> (k - 1)) & 32'd1);
        hi  = 33'(a >> k) + 33'(b >> k) + cin;
        res = (hi << k) | lo;
      end
      MODE_TRUNC: begin
        hi  = 33'(a >> k) + 33'(b >> k);
        res = hi << k;
      end
      default: begin
        hi  = '0;
        res = 33'(a) + 33'(b);
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/approx_add_core.sv
// Combinational mode-selected W-bit adder producing a W+1-bit sum.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// With APPROX_ADD_ERRMON_EN the exact sum is also produced for error tracking.
module approx_add_core
  import approx_add_pkg::*;
#(
  parameter int          W = 12,
  parameter int unsigned K = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [1:0]   mode_i,
`ifdef APPROX_ADD_ERRMON_EN
  output logic [W:0]   exact_o,
`endif
  output logic [W:0]   sum_o
);

  // Select the approximation for this beat; reserved mode falls to exact.
  always_comb begin
    sum_o = (W+1)'(approx_sum(32'(a_i), 32'(b_i), mode_e'(mode_i), K));
`ifdef APPROX_ADD_ERRMON_EN
    exact_o = (W+1)'(approx_sum(32'(a_i), 32'(b_i), MODE_EXACT, K));
`endif
  end

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined approximate adder with valid/ready; optional error monitor (APPROX_ADD_ERRMON_EN).
// Latency: STAGES cycles from acceptance to out_valid; one beat per cycle throughput.
// Backpressure: a single advance signal stalls every slice; in_ready = !out_valid | out_ready.
module approx_add_pipe
  import approx_add_pkg::*;
#(
  parameter int W      = 12,
  parameter int K      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [1:0]   mode,
`ifdef APPROX_ADD_ERRMON_EN
  input  logic         stat_clr,
  output logic [W:0]   err_max,
  output logic [31:0]  err_cnt,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   O
);

  logic              adv;
  logic [W:0]        core_sum;
  logic [STAGES-1:0] v_q, v_d;
  logic [W:0]        sum_q [STAGES];
  logic [W:0]        sum_d [STAGES];

`ifdef APPROX_ADD_ERRMON_EN
  logic [W:0]  core_exact;
  logic [W:0]  exact_q [STAGES];
  logic [W:0]  exact_d [STAGES];
  logic [W:0]  err_e;
  logic [W:0]  err_max_q, err_max_d;
  logic [31:0] err_cnt_q, err_cnt_d;
`endif

  approx_add_core #(.W(W), .K(K)) u_core (
    .a_i    (A),
    .b_i    (B),
    .mode_i (mode),
`ifdef APPROX_ADD_ERRMON_EN
    .exact_o(core_exact),
`endif
    .sum_o  (core_sum)
  );

  // Whole pipe moves together; a bubble in the last slice frees everything.
  assign adv       = !v_q[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign O         = sum_q[STAGES-1];

  // Next-state of the slices: shift on advance, otherwise hold.
  always_comb begin
    v_d   = v_q;
    sum_d = sum_q;
`ifdef APPROX_ADD_ERRMON_EN
    exact_d = exact_q;
`endif
    if (adv) begin
      v_d[0]   = in_valid;
      sum_d[0] = core_sum;
`ifdef APPROX_ADD_ERRMON_EN
      exact_d[0] = core_exact;
`endif
      for (int i = 1; i < STAGES; i++) begin
        v_d[i]   = v_q[i-1];
        sum_d[i] = sum_q[i-1];
`ifdef APPROX_ADD_ERRMON_EN
        exact_d[i] = exact_q[i-1];
`endif
      end
    end
  end

  // Slice registers; reset discards every in-flight beat and clears data.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        sum_q[i] <= '0;
`ifdef APPROX_ADD_ERRMON_EN
        exact_q[i] <= '0;
`endif
      end
    end else begin
      v_q <= v_d;
      for (int i = 0; i < STAGES; i++) begin
        sum_q[i] <= sum_d[i];
`ifdef APPROX_ADD_ERRMON_EN
        exact_q[i] <= exact_d[i];
`endif
      end
    end
  end

`ifdef APPROX_ADD_ERRMON_EN
  // Absolute error of the beat at the output and the updated statistics.
  always_comb begin
    err_e     = (O >= exact_q[STAGES-1]) ? (O - exact_q[STAGES-1])
                                         : (exact_q[STAGES-1] - O);
    err_max_d = err_max_q;
    err_cnt_d = err_cnt_q;
    if (out_valid && out_ready) begin
      if (err_e > err_max_q) err_max_d = err_e;
      if ((err_e != '0) && (err_cnt_q != 32'hFFFF_FFFF)) err_cnt_d = err_cnt_q + 32'd1;
    end
  end

  // Statistics registers; clear wins over a same-cycle update.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      err_max_q <= '0;
      err_cnt_q <= '0;
    end else begin
      err_max_q <= err_max_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_max = err_max_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Self-checking bench for approx_add_pipe (W=12, K=8, STAGES=2), scoreboard based.
// Covers reset, each mode, carry-in, stall/backpressure, reset mid-flight, random traffic.
// Error-monitor checks are built when APPROX_ADD_ERRMON_EN is defined.
module tb_approx_add_pipe;

  localparam int W = 12;
  localparam int K = 8;
  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   O;
`ifdef APPROX_ADD_ERRMON_EN
  logic         stat_clr;
  logic [W:0]   err_max;
  logic [31:0]  err_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;
  int rx_cnt = 0;
  logic [W:0] cur_exp;
  logic [W:0] exp_q [$];

  approx_add_pipe #(.W(W), .K(K), .STAGES(STAGES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .mode     (mode),
`ifdef APPROX_ADD_ERRMON_EN
    .stat_clr (stat_clr),
    .err_max  (err_max),
    .err_cnt  (err_cnt),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .O        (O)
  );

  always #5 clk = ~clk;

  // Independent model for K=8, W=12.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [1:0] m);
    logic [4:0] hi;
    logic [W:0] r;
    case (m)
      2'd1: begin
        hi = {1'b0, a[11:8]} + {1'b0, b[11:8]} + {4'd0, a[7] & b[7]};
        r  = {hi, a[7:0] | b[7:0]};
      end
      2'd2: begin
        hi = {1'b0, a[11:8]} + {1'b0, b[11:8]};
        r  = {hi, 8'h00};
      end
      default: r = {1'b0, a} + {1'b0, b};
    endcase
    return r;
  endfunction

  // Scoreboard: push on accept, pop/compare on output handshake.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      exp_q.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected O=%h with no beat pending", O);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          rx_cnt++;
          if (O !== e) $display("FAIL sb_data O=%h expected %h", O, e);
          else n_pass++;
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) exp_q.push_back(cur_exp);
    end
  end

  task automatic set_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
    A = a; B = b; mode = m; in_valid = 1'b1;
    cur_exp = model(a, b, m);
  endtask

  // Present one beat until accepted (called at posedge+1).
  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
    logic fire;
    int cyc;
    set_beat(a, b, m);
    fire = 1'b0;
    cyc = 0;
    while (!fire && cyc < 50) begin
      @(negedge clk);
      fire = in_ready;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (!fire) begin
      n_total++;
      $display("FAIL send_timeout beat not accepted in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic drain();
    int cyc;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_total++;
    if (exp_q.size() != 0) $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; mode = 2'd0;
    cur_exp = '0;
`ifdef APPROX_ADD_ERRMON_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 1'b0 || O !== '0 || in_ready !== 1'b1)
      $display("FAIL reset_state out_valid=%b O=%h in_ready=%b required 0/000/1", out_valid, O, in_ready);
    else n_pass++;
`ifdef APPROX_ADD_ERRMON_EN
    n_total++;
    if (err_max !== '0 || err_cnt !== '0)
      $display("FAIL reset_stats err_max=%h err_cnt=%0d required 0/0", err_max, err_cnt);
    else n_pass++;
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Mode 0 full-scale with latency check.
  task automatic test_exact();
    set_beat(12'hFFF, 12'hFFF, 2'd0);
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL exact_accept in_ready=%b required 1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL exact_latency_early out_valid=%b required 0", out_valid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b1 || O !== 13'h1FFE)
      $display("FAIL exact_result out_valid=%b O=%h required 1/1ffe", out_valid, O);
    else n_pass++;
    @(posedge clk); #1;
    drain();
`ifdef APPROX_ADD_ERRMON_EN
    n_total++;
    if (err_max !== '0 || err_cnt !== 32'd0)
      $display("FAIL exact_stats err_max=%h err_cnt=%0d required 0/0", err_max, err_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_loa();
    send_beat(12'h0FF, 12'h001, 2'd1);
    n_total++;
    if (cur_exp !== 13'h00FF) $display("FAIL loa_model exp=%h required 00ff", cur_exp);
    else n_pass++;
    drain();
`ifdef APPROX_ADD_ERRMON_EN
    n_total++;
    if (err_max !== 13'h001 || err_cnt !== 32'd1)
      $display("FAIL loa_stats err_max=%h err_cnt=%0d required 001/1", err_max, err_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_trunc();
    send_beat(12'hFFF, 12'hFFF, 2'd2);
    n_total++;
    if (cur_exp !== 13'h1E00) $display("FAIL trunc_model exp=%h required 1e00", cur_exp);
    else n_pass++;
    drain();
`ifdef APPROX_ADD_ERRMON_EN
    n_total++;
    if (err_max !== 13'h1FE || err_cnt !== 32'd2)
      $display("FAIL trunc_stats err_max=%h err_cnt=%0d required 1fe/2", err_max, err_cnt);
    else n_pass++;
`endif
  endtask

  // LOA carry-in from bit K-1: 0x180 vs exact 0x100, error 0x80.
  task automatic test_loa_carry();
    send_beat(12'h080, 12'h080, 2'd1);
    n_total++;
    if (cur_exp !== 13'h0180) $display("FAIL carry_model exp=%h required 0180", cur_exp);
    else n_pass++;
    drain();
`ifdef APPROX_ADD_ERRMON_EN
    n_total++;
    if (err_max !== 13'h1FE || err_cnt !== 32'd3)
      $display("FAIL carry_stats err_max=%h err_cnt=%0d required 1fe/3", err_max, err_cnt);
    else n_pass++;
`endif
    send_beat(12'h123, 12'h456, 2'd3);
    drain();
  endtask

`ifdef APPROX_ADD_ERRMON_EN
  // stat_clr coincides with an erroneous output handshake: clear wins.
  task automatic test_stat_clr();
    int cyc;
    out_ready = 1'b0;
    send_beat(12'h0FF, 12'h001, 2'd1);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    n_total++;
    if (err_max !== '0 || err_cnt !== 32'd0)
      $display("FAIL statclr_priority err_max=%h err_cnt=%0d required 0/0", err_max, err_cnt);
    else n_pass++;
    drain();
  endtask
`endif

  // Four beats back-to-back with a 3-cycle output stall after the first result.
  task automatic test_back_to_back();
    int idx, hold, rx0;
    logic fire, seen_first, saw_block, prev_stall;
    logic [W:0] prev_o;
    idx = 0; hold = 0; seen_first = 1'b0; saw_block = 1'b0; prev_stall = 1'b0;
    prev_o = '0;
    rx0 = rx_cnt;
    for (int cyc = 0; cyc < 60 && (idx < 4 || exp_q.size() != 0); cyc++) begin
      if (idx < 4) set_beat(12'(idx * 12'h111 + 12'h0F0), 12'(idx * 12'h207 + 12'h081), 2'(idx));
      else in_valid = 1'b0;
      out_ready = (hold == 0);
      if (hold > 0) hold--;
      @(negedge clk);
      fire = in_valid && in_ready;
      if (in_ready === 1'b0) saw_block = 1'b1;
      if (prev_stall && out_valid === 1'b1) begin
        n_total++;
        if (O !== prev_o) $display("FAIL stall_hold O=%h required %h", O, prev_o);
        else n_pass++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_o = O;
      if (!seen_first && out_valid === 1'b1) begin
        seen_first = 1'b1;
        hold = 3;
      end
      @(posedge clk); #1;
      if (fire) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_total++;
    if (!saw_block) $display("FAIL b2b_backpressure in_ready_low=%b required 1", saw_block);
    else n_pass++;
    n_total++;
    if (rx_cnt - rx0 != 4 || exp_q.size() != 0)
      $display("FAIL b2b_count received=%0d pending=%0d required 4/0", rx_cnt - rx0, exp_q.size());
    else n_pass++;
  endtask

  // Reset with two beats in flight.
  task automatic test_reset_midflight();
    out_ready = 1'b0;
    send_beat(12'h111, 12'h222, 2'd0);
    send_beat(12'h333, 12'h444, 2'd1);
    set_beat(12'h555, 12'h666, 2'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || O !== '0 || in_ready !== 1'b1)
      $display("FAIL rst_flight out_valid=%b O=%h in_ready=%b required 0/000/1", out_valid, O, in_ready);
    else n_pass++;
`ifdef APPROX_ADD_ERRMON_EN
    n_total++;
    if (err_max !== '0 || err_cnt !== '0)
      $display("FAIL rst_flight_stats err_max=%h err_cnt=%0d required 0/0", err_max, err_cnt);
    else n_pass++;
`endif
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL rst_ignored_in out_valid=%b required 0", out_valid);
    else n_pass++;
    out_ready = 1'b1;
    send_beat(12'hABC, 12'h345, 2'd2);
    drain();
  endtask

  task automatic test_random();
    int sent, rx0;
    logic fire;
    sent = 0;
    rx0 = rx_cnt;
    for (int cyc = 0; cyc < 400 && sent < 40; cyc++) begin
      if ($urandom_range(0, 3) != 0)
        set_beat(12'($urandom), 12'($urandom), 2'($urandom_range(0, 3)));
      else
        in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) sent++;
    end
    in_valid = 1'b0;
    drain();
    n_total++;
    if (rx_cnt - rx0 != sent || sent != 40)
      $display("FAIL random_count received=%0d sent=%0d required 40/40", rx_cnt - rx0, sent);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_exact();
    test_loa();
    test_trunc();
    test_loa_carry();
`ifdef APPROX_ADD_ERRMON_EN
    test_stat_clr();
`endif
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
